// File: rtl/fifo_rd_fwft.sv
// Read-side output stage of the async FIFO: converts the pop interface into a
// first-word-fall-through valid/ready stream with a 2-entry (head + skid) buffer.
module fifo_rd_fwft #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_r,
    input  logic                  rst_r,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_en,
    input  logic                  rd_enable,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [1:0]            buf_level,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [1:0]            level_q;
    logic                  inflight_q;
    logic                  drop_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic                  pop;
    logic                  capture;
    logic                  head_free;
    logic [2:0]            occupancy;

    assign dout       = head_q;
    assign dout_valid = (level_q != 2'd0);
    assign buf_level  = level_q;
    assign word_cnt   = cnt_q;

    assign pop       = dout_valid & dout_ready;
    // Occupancy counts the word already requested, so the buffer can never overflow.
    assign occupancy = {1'b0, level_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign r_en      = ~rst_r & ~flush & rd_enable & ~empty & (occupancy < 3'd2);
    assign capture   = inflight_q & ~drop_q & ~flush;
    assign head_free = (level_q == 2'd0) | (pop & (level_q == 2'd1));

    always_ff @(posedge clk_r) begin
        if (rst_r) begin
            head_q     <= '0;
            skid_q     <= '0;
            level_q    <= 2'd0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= r_en;
            drop_q     <= flush & inflight_q;
            if (pop) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
            if (flush) begin
                level_q <= 2'd0;
            end else begin
                level_q <= level_q - {1'b0, pop} + {1'b0, capture};
                // A new word lands in head only when nothing older is waiting in front of it.
                if (capture && head_free) begin
                    head_q <= r_data;
                end else if (pop && (level_q == 2'd2)) begin
                    head_q <= skid_q;
                end
                if (capture && !head_free) begin
                    skid_q <= r_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Scoreboard bench for fifo_rd_fwft: requested words are queued as expected output
// and a monitor compares them against the stream, level, r_en and counter.
module tb_fifo_rd_fwft;

    localparam int DW = 16;
    localparam int CW = 16;

    logic          clk_r = 1'b0;
    logic          rst_r;
    logic          empty;
    logic [DW-1:0] r_data;
    logic          r_en;
    logic          rd_enable;
    logic          flush;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [1:0]    buf_level;
    logic [CW-1:0] word_cnt;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rdata_next;
    bit            inflight_m;
    int unsigned   pops_total;
    int            ren_count;

    int m_lvl;
    bit m_vld;
    bit m_pop;
    bit m_ren;

    fifo_rd_fwft #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_r      (clk_r),
        .rst_r      (rst_r),
        .empty      (empty),
        .r_data     (r_data),
        .r_en       (r_en),
        .rd_enable  (rd_enable),
        .flush      (flush),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .buf_level  (buf_level),
        .word_cnt   (word_cnt)
    );

    always #5 clk_r = ~clk_r;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle: drive inputs, then record what the FIFO handed over.
    task automatic apply_stimulus(input bit rst, input bit en, input bit ready, input bit fe, input bit fl);
        @(negedge clk_r);
        rst_r      = rst;
        rd_enable  = en;
        dout_ready = ready;
        flush      = fl;
        empty      = fe || (src_q.size() == 0);
        r_data     = inflight_m ? rdata_next : DW'($urandom);
        #2;
        if (rst) begin
            exp_q.delete();
            inflight_m = 1'b0;
            pops_total = 0;
        end else begin
            inflight_m = 1'b0;
            if (r_en) begin
                ren_count++;
                if (src_q.size() > 0) begin
                    rdata_next = src_q.pop_front();
                    exp_q.push_back(rdata_next);
                    inflight_m = 1'b1;
                end
            end
            if (fl) begin
                exp_q.delete();
                inflight_m = 1'b0;
            end
        end
    endtask

    task automatic load_words(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            src_q.push_back(base + DW'(i));
        end
    endtask

    task automatic drain_check(input string name);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            apply_stimulus(0, 0, 1, 0, 0);
        end
        check_output(name, exp_q.size(), 0);
    endtask

    // Monitor: the model level is every requested word not yet delivered, minus the one still in flight.
    initial begin
        forever begin
            @(negedge clk_r);
            #1;
            if (rst_r) begin
                check_output("r_en_in_reset", r_en, 0);
            end else begin
                m_lvl = exp_q.size() - int'(inflight_m);
                m_vld = (m_lvl > 0);
                m_pop = m_vld && dout_ready;
                m_ren = !flush && rd_enable && !empty && ((exp_q.size() - int'(m_pop)) < 2);
                check_output("buf_level", buf_level, m_lvl);
                check_output("dout_valid", dout_valid, m_vld);
                check_output("word_cnt", word_cnt, CW'(pops_total));
                check_output("r_en", r_en, m_ren);
                if (m_vld) begin
                    check_output("dout", dout, exp_q[0]);
                    if (m_pop) begin
                        void'(exp_q.pop_front());
                        pops_total++;
                    end
                end
            end
        end
    end

    initial begin
        rst_r      = 1'b1;
        rd_enable  = 1'b0;
        dout_ready = 1'b0;
        flush      = 1'b0;
        empty      = 1'b1;
        r_data     = '0;
        rdata_next = '0;
        inflight_m = 1'b0;
        pops_total = 0;
        ren_count  = 0;

        repeat (3) apply_stimulus(1, 1, 1, 0, 0);
        check_output("rst_dout", dout, 0);
        check_output("rst_dout_valid", dout_valid, 0);
        check_output("rst_buf_level", buf_level, 0);
        check_output("rst_word_cnt", word_cnt, 0);

        // Four words streamed back to back.
        load_words(16'hA000, 4);
        ren_count = 0;
        repeat (8) apply_stimulus(0, 1, 1, 0, 0);
        check_output("stream_ren_count", ren_count, 4);
        check_output("stream_word_cnt", word_cnt, 4);
        check_output("stream_drained", exp_q.size(), 0);

        // Consumer stalled: only two words may be fetched.
        load_words(16'hB000, 5);
        ren_count = 0;
        repeat (6) apply_stimulus(0, 1, 0, 0, 0);
        check_output("stall_ren_count", ren_count, 2);
        check_output("stall_buf_level", buf_level, 2);
        check_output("stall_dout", dout, 16'hB000);
        repeat (10) apply_stimulus(0, 1, 1, 0, 0);
        check_output("stall_ren_total", ren_count, 5);
        drain_check("stall_drained");

        // Empty flag toggling every cycle.
        load_words(16'hC000, 6);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(0, 1, 1, (i % 2) == 0, 0);
        end
        drain_check("toggle_drained");

        // Flush while a word is in flight.
        load_words(16'hD000, 6);
        apply_stimulus(0, 1, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 1);
        apply_stimulus(0, 1, 1, 0, 0);
        check_output("flush_buf_level", buf_level, 0);
        check_output("flush_dout_valid", dout_valid, 0);
        repeat (10) apply_stimulus(0, 1, 1, 0, 0);
        drain_check("flush_drained");

        // Prefetch disabled with a full buffer: it drains and stays idle.
        load_words(16'hE000, 4);
        repeat (4) apply_stimulus(0, 1, 0, 0, 0);
        check_output("disable_fill_level", buf_level, 2);
        ren_count = 0;
        repeat (5) apply_stimulus(0, 0, 1, 0, 0);
        check_output("disable_ren_count", ren_count, 0);
        check_output("disable_drained", exp_q.size(), 0);
        check_output("disable_dout_valid", dout_valid, 0);

        // Randomized traffic with sparse flushes and one mid-stream reset.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) != 0 && src_q.size() < 8) begin
                src_q.push_back(DW'($urandom));
            end
            apply_stimulus(i == 750,
                           $urandom_range(0, 99) < 90,
                           $urandom_range(0, 99) < 75,
                           $urandom_range(0, 99) < 25,
                           $urandom_range(0, 99) < 3);
        end
        drain_check("random_drained");

        // Full-rate stream until the delivered-word counter wraps.
        for (int i = 0; i < 70000 && pops_total < 65536; i++) begin
            if (src_q.size() < 4) begin
                src_q.push_back(DW'($urandom));
            end
            apply_stimulus(0, 1, 1, 0, 0);
        end
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("wrap_pops", pops_total, 65536);
        check_output("wrap_word_cnt", word_cnt, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
